// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the seg7_scan_ctrl display controller
package seg7_pkg;
  localparam logic MODE_HEX = 1'b0;
  localparam logic MODE_RAW = 1'b1;
  localparam logic [7:0] SEG_OFF = 8'h00;
  localparam logic [3:0] PH_BLANK = 4'd0;
  localparam logic [3:0] PH_LAST = 4'd15;
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
endpackage

// File: rtl/seg7_scan_ctrl_fmt.sv
// seg7_digit_fmt: turns one digit's shadow data into the final polarity-adjusted segment byte
module seg7_digit_fmt
  import seg7_pkg::*;
#(
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic [7:0] i_byte,
  input  logic       i_dp,
  input  logic       i_mode,
  input  logic       i_blank,
  output logic [7:0] o_seg
);
  logic [7:0] pat;
  // Active-high pattern: blank wins, raw passes through, hex decodes with dp on top
  always_comb begin
    pat = i_blank ? SEG_OFF : i_mode == MODE_RAW ? i_byte : {i_dp, HEX_SEG[i_byte[3:0]]};
  end
  assign o_seg = (SEG_ACTIVE_LOW != 0) ? ~pat : pat;
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed 7-segment scanner with PWM, lz-suppression, frame-synchronous update; optional blink via SEG7_BLINK_EN
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int SCAN_DIV       = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_load,
  input  logic                    i_mode,
  input  logic                    i_lz,
  input  logic [8*NUM_DIGITS-1:0] i_data,
  input  logic [NUM_DIGITS-1:0]   i_dp,
`ifdef SEG7_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   i_blink,
`endif
  input  logic [3:0]              i_brightness,
  output logic [7:0]              o_seg,
  output logic [NUM_DIGITS-1:0]   o_sel,
  output logic                    o_frame
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int W = 8 * NUM_DIGITS;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
  localparam logic [7:0] SEG_RST = (SEG_ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{SEL_ACTIVE_LOW != 0}};
  localparam logic [NUM_DIGITS-1:0] ONE = NUM_DIGITS'(1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] ph_q, ph_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0] stg_data_q, stg_data_d, shd_data_q, shd_data_d;
  logic [NUM_DIGITS-1:0] stg_dp_q, stg_dp_d, shd_dp_q, shd_dp_d;
  logic stg_mode_q, stg_mode_d, shd_mode_q, shd_mode_d;
  logic stg_lz_q, stg_lz_d, shd_lz_q, shd_lz_d;
  logic pend_q, pend_d;
  logic [7:0] seg_q, seg_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic tick, frame, lit, lz_blank, blink_blank;
  logic [7:0] dig_byte, fmt_seg;

  // Prescaler, slot phase and digit index; frame is the cycle the index wraps
  always_comb begin
    tick = cnt_q == CNT_MAX;
    frame = tick && ph_q == PH_LAST && idx_q == IDX_MAX;
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    ph_d = tick ? ph_q + 1'b1 : ph_q;
    idx_d = (tick && ph_q == PH_LAST) ? (idx_q == IDX_MAX ? '0 : idx_q + 1'b1) : idx_q;
  end

  // Loads go to staging; a pending staging copy moves to shadow only at a frame boundary
  always_comb begin
    stg_data_d = i_load ? i_data : stg_data_q;
    stg_dp_d = i_load ? i_dp : stg_dp_q;
    stg_mode_d = i_load ? i_mode : stg_mode_q;
    stg_lz_d = i_load ? i_lz : stg_lz_q;
    pend_d = i_load | (pend_q & ~frame);
    shd_data_d = (frame && pend_q) ? stg_data_q : shd_data_q;
    shd_dp_d = (frame && pend_q) ? stg_dp_q : shd_dp_q;
    shd_mode_d = (frame && pend_q) ? stg_mode_q : shd_mode_q;
    shd_lz_d = (frame && pend_q) ? stg_lz_q : shd_lz_q;
  end

`ifdef SEG7_BLINK_EN
  logic [NUM_DIGITS-1:0] stg_blink_q, stg_blink_d, shd_blink_q, shd_blink_d;
  logic [5:0] fc_q, fc_d;
  // Blink mask follows the same staging path; frame counter sets the blink period
  always_comb begin
    stg_blink_d = i_load ? i_blink : stg_blink_q;
    shd_blink_d = (frame && pend_q) ? stg_blink_q : shd_blink_q;
    fc_d = frame ? fc_q + 1'b1 : fc_q;
    blink_blank = fc_q[5] & shd_blink_q[idx_q];
  end
  // Blink state registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stg_blink_q <= '0;
      shd_blink_q <= '0;
      fc_q <= '0;
    end else begin
      stg_blink_q <= stg_blink_d;
      shd_blink_q <= shd_blink_d;
      fc_q <= fc_d;
    end
  end
`else
  assign blink_blank = 1'b0;
`endif

  // Select current digit's data and decide lit/blank for this phase
  always_comb begin
    lit = ph_q != PH_BLANK && ph_q <= i_brightness;
    dig_byte = shd_mode_q == MODE_RAW ? shd_data_q[{idx_q, 3'b000} +: 8]
                                      : {4'h0, shd_data_q[{idx_q, 2'b00} +: 4]};
    lz_blank = shd_lz_q && shd_mode_q == MODE_HEX && idx_q != '0;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (k >= int'(idx_q) && shd_data_q[4*k +: 4] != 4'h0) lz_blank = 1'b0;
    seg_d = fmt_seg;
    sel_d = lit ? (ONE << idx_q) ^ SEL_OFF : SEL_OFF;
  end

  seg7_digit_fmt #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_fmt (
    .i_byte (dig_byte),
    .i_dp   (shd_dp_q[idx_q]),
    .i_mode (shd_mode_q),
    .i_blank(~lit | lz_blank | blink_blank),
    .o_seg  (fmt_seg)
  );

  // Counters, staging/shadow and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
      ph_q <= '0;
      idx_q <= '0;
      stg_data_q <= '0;
      stg_dp_q <= '0;
      stg_mode_q <= 1'b0;
      stg_lz_q <= 1'b0;
      shd_data_q <= '0;
      shd_dp_q <= '0;
      shd_mode_q <= 1'b0;
      shd_lz_q <= 1'b0;
      pend_q <= 1'b0;
      seg_q <= SEG_RST;
      sel_q <= SEL_OFF;
    end else begin
      cnt_q <= cnt_d;
      ph_q <= ph_d;
      idx_q <= idx_d;
      stg_data_q <= stg_data_d;
      stg_dp_q <= stg_dp_d;
      stg_mode_q <= stg_mode_d;
      stg_lz_q <= stg_lz_d;
      shd_data_q <= shd_data_d;
      shd_dp_q <= shd_dp_d;
      shd_mode_q <= shd_mode_d;
      shd_lz_q <= shd_lz_d;
      pend_q <= pend_d;
      seg_q <= seg_d;
      sel_q <= sel_d;
    end
  end

  assign o_seg = seg_q;
  assign o_sel = sel_q;
  assign o_frame = frame;
endmodule
